// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock core.
//   state_e    : edit/run state of the front-panel FSM
//   HOURS, MINUTES, SECONDS : modulus of each time field
//   bin_to_bcd : converts a binary value 0..99 into two packed BCD digits
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_AL_HOUR,
    SET_AL_MIN
  } state_e;

  localparam int HOURS   = 24;
  localparam int MINUTES = 60;
  localparam int SECONDS = 60;

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter used for every time and alarm field.
//   clk   : rising-edge clock
//   clr   : asynchronous active-high reset, value returns to 0
//   inc   : advance by one this cycle, wrapping MOD-1 -> 0
//   load0 : force value to 0 (wins over inc)
//   value : current count
//   carry : high in the cycle inc wraps the counter from MOD-1 to 0
module mod_counter #(
  parameter int MOD = 60,
  localparam int W = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         load0,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;

  // Next count: explicit clear first, otherwise wrap-around increment.
  always_comb begin
    value_d = value_q;
    if (load0) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == MAX) ? '0 : value_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && !load0 && (value_q == MAX);

endmodule

// File: rtl/alarm_clock_core.sv
// Alarm clock core: seconds divider, time-of-day counters, alarm setting,
// edit FSM, alarm ringing and a registered BCD display word.
//   clk      : system clock
//   clr      : asynchronous active-high reset
//   mode_btn : one-cycle pulse, steps RUN->SET_HOUR->SET_MIN->SET_AL_HOUR->SET_AL_MIN->RUN
//   inc_btn  : one-cycle pulse, increments the field being edited
//   alarm_en : level, arms the alarm
//   fmt_12h  : level, 1 selects 12-hour display
//   disp     : {8'h00, HH, MM, SS} BCD, alarm shown as {HH, MM, 8'h00} in alarm edit
//   blink    : {hour, min, sec} edit mask
//   pm       : displayed hour is 12..23 and fmt_12h is set
//   ring     : alarm active
//   sec_tick : one-cycle pulse per second while time runs
module alarm_clock_core #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int RING_SECS = 60
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        alarm_en,
  input  logic        fmt_12h,
  output logic [31:0] disp,
  output logic [2:0]  blink,
  output logic        pm,
  output logic        ring,
  output logic        sec_tick
);
  import clock_pkg::*;

  localparam int              DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]      RING_LOAD = 8'(RING_SECS);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ring_q, ring_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [31:0]      disp_q, disp_d;
  logic             pm_q, pm_d;

  logic [5:0] sec_v, min_v, al_min_v;
  logic [4:0] hour_v, al_hour_v;
  logic       sec_carry, min_carry, hour_carry, al_hour_carry, al_min_carry;
  logic       unused_alarm_carries;

  logic       running, consume, mode_act, inc_act, leave_set_min;
  logic       hour_btn, min_btn, al_hour_btn, al_min_btn;
  logic [5:0] min_next;
  logic [4:0] hour_next;
  logic       alarm_hit;
  logic       al_view;
  logic [4:0] hour_sel, hour_shown;
  logic [5:0] min_sel, sec_sel;

  // A button press while ringing only silences the alarm; mode beats inc.
  always_comb begin
    running       = (state_q == RUN) || (state_q == SET_AL_HOUR) || (state_q == SET_AL_MIN);
    sec_tick      = running && (div_q == DIV_MAX);
    consume       = ring && (mode_btn || inc_btn);
    mode_act      = mode_btn && !consume;
    inc_act       = inc_btn && !mode_btn && !consume;
    leave_set_min = mode_act && (state_q == SET_MIN);
    hour_btn      = inc_act && (state_q == SET_HOUR);
    min_btn       = inc_act && (state_q == SET_MIN);
    al_hour_btn   = inc_act && (state_q == SET_AL_HOUR);
    al_min_btn    = inc_act && (state_q == SET_AL_MIN);
  end

  // Edit FSM next state.
  always_comb begin
    state_d = state_q;
    if (mode_act) begin
      case (state_q)
        RUN:         state_d = SET_HOUR;
        SET_HOUR:    state_d = SET_MIN;
        SET_MIN:     state_d = SET_AL_HOUR;
        SET_AL_HOUR: state_d = SET_AL_MIN;
        SET_AL_MIN:  state_d = RUN;
        default:     state_d = RUN;
      endcase
    end
  end

  // Seconds divider: frozen while editing time, restarted when minutes are committed.
  always_comb begin
    div_d = div_q;
    if (leave_set_min) begin
      div_d = '0;
    end else if (running) begin
      div_d = sec_tick ? '0 : div_q + DIV_W'(1);
    end
  end

  mod_counter #(.MOD(SECONDS)) u_sec (
    .clk(clk), .clr(clr), .inc(sec_tick), .load0(leave_set_min),
    .value(sec_v), .carry(sec_carry)
  );

  mod_counter #(.MOD(MINUTES)) u_min (
    .clk(clk), .clr(clr), .inc(sec_carry || min_btn), .load0(1'b0),
    .value(min_v), .carry(min_carry)
  );

  // Only a tick-driven minute wrap carries into hours; editing minutes never does.
  mod_counter #(.MOD(HOURS)) u_hour (
    .clk(clk), .clr(clr), .inc((sec_carry && min_carry) || hour_btn), .load0(1'b0),
    .value(hour_v), .carry(hour_carry)
  );

  mod_counter #(.MOD(HOURS)) u_al_hour (
    .clk(clk), .clr(clr), .inc(al_hour_btn), .load0(1'b0),
    .value(al_hour_v), .carry(al_hour_carry)
  );

  mod_counter #(.MOD(MINUTES)) u_al_min (
    .clk(clk), .clr(clr), .inc(al_min_btn), .load0(1'b0),
    .value(al_min_v), .carry(al_min_carry)
  );

  assign unused_alarm_carries = al_hour_carry | al_min_carry;

  // Alarm match looks at the time this tick is about to produce, so ring
  // rises in the cycle right after the matching tick.
  always_comb begin
    min_next  = min_carry ? 6'd0 : min_v + 6'd1;
    hour_next = hour_carry ? 5'd0 : (min_carry ? hour_v + 5'd1 : hour_v);
    alarm_hit = sec_carry && (min_next == al_min_v) && (hour_next == al_hour_v);
  end

  // Ring control: disarm and button presses win, then the duration countdown,
  // and a fresh match only starts ringing when idle.
  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (!alarm_en || consume) begin
      ring_d = 1'b0;
    end else if (ring_q) begin
      if (sec_tick) begin
        if (ring_cnt_q <= 8'd1) begin
          ring_d = 1'b0;
        end else begin
          ring_cnt_d = ring_cnt_q - 8'd1;
        end
      end
    end else if (alarm_hit) begin
      ring_d     = 1'b1;
      ring_cnt_d = RING_LOAD;
    end
  end

  // Display source selection and 12-hour mapping.
  always_comb begin
    al_view  = (state_q == SET_AL_HOUR) || (state_q == SET_AL_MIN);
    hour_sel = al_view ? al_hour_v : hour_v;
    min_sel  = al_view ? al_min_v : min_v;
    sec_sel  = al_view ? 6'd0 : sec_v;
    hour_shown = hour_sel;
    if (fmt_12h) begin
      if (hour_sel == 5'd0) begin
        hour_shown = 5'd12;
      end else if (hour_sel > 5'd12) begin
        hour_shown = hour_sel - 5'd12;
      end
    end
    pm_d   = fmt_12h && (hour_sel >= 5'd12);
    disp_d = {8'h00, bin_to_bcd(7'(hour_shown)), bin_to_bcd(7'(min_sel)),
              bin_to_bcd(7'(sec_sel))};
  end

  // Field-edit mask straight from the state.
  always_comb begin
    blink = 3'b000;
    case (state_q)
      SET_HOUR, SET_AL_HOUR: blink = 3'b100;
      SET_MIN, SET_AL_MIN:   blink = 3'b010;
      default:               blink = 3'b000;
    endcase
  end

  // State, divider, ring and display registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= RUN;
      div_q      <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
      disp_q     <= 32'h0000_0000;
      pm_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      disp_q     <= disp_d;
      pm_q       <= pm_d;
    end
  end

  assign ring = ring_q && alarm_en;
  assign disp = disp_q;
  assign pm   = pm_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Self-checking bench for alarm_clock_core with TICK_DIV=4, RING_SECS=3.
module tb_alarm_clock_core;

  localparam int TICK_DIV  = 4;
  localparam int RING_SECS = 3;

  logic        clk      = 1'b0;
  logic        clr      = 1'b1;
  logic        mode_btn = 1'b0;
  logic        inc_btn  = 1'b0;
  logic        alarm_en = 1'b0;
  logic        fmt_12h  = 1'b0;
  logic [31:0] disp;
  logic [2:0]  blink;
  logic        pm;
  logic        ring;
  logic        sec_tick;

  int   errors = 0;
  int   checks = 0;
  logic saw_hour24 = 1'b0;

  typedef struct {
    logic        mode;
    logic        inc;
    logic [31:0] exp_disp;
    logic [2:0]  exp_blink;
  } edit_vec_t;

  typedef struct {
    int         incs;
    logic       fmt;
    logic [7:0] exp_hour;
    logic       exp_pm;
  } hour_vec_t;

  edit_vec_t edit_vecs[10];
  hour_vec_t hour_vecs[5];

  always #5 clk = ~clk;

  alarm_clock_core #(.TICK_DIV(TICK_DIV), .RING_SECS(RING_SECS)) dut (
    .clk(clk), .clr(clr), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .alarm_en(alarm_en), .fmt_12h(fmt_12h), .disp(disp), .blink(blink),
    .pm(pm), .ring(ring), .sec_tick(sec_tick)
  );

  // Watch for an illegal hour 24 ever reaching the display.
  always @(negedge clk) begin
    if (!clr && disp[23:16] == 8'h24) saw_hour24 <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
    step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  // One button cycle plus one idle cycle so the registered display catches up.
  task automatic applyStimulus(input logic m, input logic i);
    pulse(m, i);
    step();
  endtask

  task automatic do_reset();
    clr      = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    alarm_en = 1'b0;
    fmt_12h  = 1'b0;
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic wait_ticks(input int n, input string name);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * TICK_DIV * 3 + 8) begin
      @(negedge clk);
      cyc++;
      if (sec_tick === 1'b1) seen++;
    end
    checkOutput(name, 32'(seen), 32'(n));
    @(posedge clk);
    #1;
  endtask

  // Clear, then alarm 00:01 armed, time 00:00:00 in RUN with the first tick next cycle.
  task automatic setup_alarm_0001();
    do_reset();
    alarm_en = 1'b1;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    int cyc;

    edit_vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 3'b100};
    edit_vecs[1] = '{1'b0, 1'b1, 32'h0001_0000, 3'b100};
    edit_vecs[2] = '{1'b1, 1'b1, 32'h0001_0000, 3'b010};
    edit_vecs[3] = '{1'b0, 1'b1, 32'h0001_0100, 3'b010};
    edit_vecs[4] = '{1'b0, 1'b1, 32'h0001_0200, 3'b010};
    edit_vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 3'b100};
    edit_vecs[6] = '{1'b0, 1'b1, 32'h0001_0000, 3'b100};
    edit_vecs[7] = '{1'b1, 1'b0, 32'h0001_0000, 3'b010};
    edit_vecs[8] = '{1'b0, 1'b1, 32'h0001_0100, 3'b010};
    edit_vecs[9] = '{1'b1, 1'b0, 32'h0001_0202, 3'b000};

    hour_vecs[0] = '{13, 1'b1, 8'h01, 1'b1};
    hour_vecs[1] = '{0,  1'b0, 8'h13, 1'b0};
    hour_vecs[2] = '{11, 1'b1, 8'h12, 1'b0};
    hour_vecs[3] = '{12, 1'b1, 8'h12, 1'b1};
    hour_vecs[4] = '{11, 1'b1, 8'h11, 1'b1};

    // Reset state.
    do_reset();
    checkOutput("reset_disp", disp, 32'h0);
    checkOutput("reset_blink", 32'(blink), 32'h0);
    checkOutput("reset_pm", 32'(pm), 32'h0);
    checkOutput("reset_ring", 32'(ring), 32'h0);
    checkOutput("reset_tick", 32'(sec_tick), 32'h0);

    // Edit walk: time 01:02, alarm 01:01, including mode+inc in the same cycle.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(edit_vecs[k].mode, edit_vecs[k].inc);
      checkOutput($sformatf("edit%0d_disp", k), disp, edit_vecs[k].exp_disp);
      checkOutput($sformatf("edit%0d_blink", k), 32'(blink), 32'(edit_vecs[k].exp_blink));
      checkOutput($sformatf("edit%0d_ring", k), 32'(ring), 32'h0);
    end

    // 12/24-hour mapping while editing hours.
    do_reset();
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      fmt_12h = hour_vecs[k].fmt;
      for (int j = 0; j < hour_vecs[k].incs; j++) applyStimulus(1'b0, 1'b1);
      step();
      step();
      checkOutput($sformatf("hour%0d_disp", k), disp, {8'h00, hour_vecs[k].exp_hour, 16'h0000});
      checkOutput($sformatf("hour%0d_pm", k), 32'(pm), 32'(hour_vecs[k].exp_pm));
    end

    // Three modes then five incs: alarm hour 05.
    do_reset();
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("alarm05_disp", disp, 32'h0005_0000);
    checkOutput("alarm05_blink", 32'(blink), 32'b100);

    // Rollover 23:59:59 -> 00:00:00 in one tick.
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (23) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    repeat (3) pulse(1'b1, 1'b0);
    wait_ticks(59, "roll_ticks59");
    step();
    checkOutput("roll_235959", disp, 32'h0023_5959);
    wait_ticks(1, "roll_tick1");
    step();
    checkOutput("roll_000000", disp, 32'h0000_0000);
    checkOutput("roll_no_hour24", 32'(saw_hour24), 32'h0);

    // Alarm 00:01 rings after tick 60 and stops after three more ticks.
    setup_alarm_0001();
    wait_ticks(59, "ring_ticks59");
    checkOutput("ring_before_match", 32'(ring), 32'h0);
    wait_ticks(1, "ring_tick60");
    checkOutput("ring_rise", 32'(ring), 32'h1);
    step();
    checkOutput("ring_time_0001", disp, 32'h0000_0100);
    wait_ticks(2, "ring_ticks62");
    checkOutput("ring_still_high", 32'(ring), 32'h1);
    wait_ticks(1, "ring_tick63");
    checkOutput("ring_fall", 32'(ring), 32'h0);

    // Button while ringing only silences; time, alarm and state untouched.
    setup_alarm_0001();
    wait_ticks(60, "silence_ticks");
    checkOutput("silence_ring_on", 32'(ring), 32'h1);
    pulse(1'b0, 1'b1);
    checkOutput("silence_ring_off", 32'(ring), 32'h0);
    checkOutput("silence_blink_run", 32'(blink), 32'h0);
    step();
    checkOutput("silence_time", disp, 32'h0000_0100);
    repeat (3) pulse(1'b1, 1'b0);
    step();
    checkOutput("silence_alarm", disp, 32'h0000_0100);
    checkOutput("silence_al_blink", 32'(blink), 32'b100);

    // Dropping alarm_en silences at once and clears the ring register.
    setup_alarm_0001();
    wait_ticks(60, "disarm_ticks");
    checkOutput("disarm_ring_on", 32'(ring), 32'h1);
    alarm_en = 1'b0;
    #1;
    checkOutput("disarm_immediate", 32'(ring), 32'h0);
    step();
    alarm_en = 1'b1;
    #1;
    checkOutput("disarm_cleared", 32'(ring), 32'h0);

    // Asynchronous clear in the middle of minute editing.
    do_reset();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("preclr_disp", disp, 32'h0000_0200);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("clr_disp", disp, 32'h0);
    checkOutput("clr_blink", 32'(blink), 32'h0);
    checkOutput("clr_pm", 32'(pm), 32'h0);
    checkOutput("clr_tick", 32'(sec_tick), 32'h0);
    step();
    clr = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (sec_tick !== 1'b1 && cyc < 20);
    checkOutput("clr_first_tick", 32'(cyc), 32'(TICK_DIV));
    checkOutput("clr_time_zero", disp, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_clock_core.md
ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per one-second tick (>=2).
REQ-002 Parameter RING_SECS, default 60, alarm ring duration in seconds (1..255).
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port clr  input  1  reset, asynchronous, active-high.
REQ-005 Port mode_btn  input  1  single-cycle pulse, advances edit state.
REQ-006 Port inc_btn  input  1  single-cycle pulse, increments field being edited.
REQ-007 Port alarm_en  input  1  level, arms alarm.
REQ-008 Port fmt_12h  input  1  level, 1 = 12-hour display, 0 = 24-hour.
REQ-009 Port disp  output  32  BCD word {8'h00, HH, MM, SS} for the 8-digit display driver.
REQ-010 Port blink  output  3  field-edit mask {hour, min, sec}.
REQ-011 Port pm  output  1  high when displayed hour is 12:00-23:59 and fmt_12h=1.
REQ-012 Port ring  output  1  alarm active.
REQ-013 Port sec_tick  output  1  one-cycle pulse per second while time runs.

Function
REQ-014 Divider counts 0..TICK_DIV-1; sec_tick high exactly in the cycle count==TICK_DIV-1, then count returns to 0.
REQ-015 FSM states RUN, SET_HOUR, SET_MIN, SET_AL_HOUR, SET_AL_MIN; mode_btn moves RUN->SET_HOUR->SET_MIN->SET_AL_HOUR->SET_AL_MIN->RUN, one step per pulse.
REQ-016 Time (h 0..23, m 0..59, s 0..59, binary) advances only in RUN, AL states included? No: advances in RUN, SET_AL_HOUR, SET_AL_MIN; in SET_HOUR/SET_MIN divider and time are frozen.
REQ-017 On sec_tick: s wraps 59->0 carrying to m; m wraps 59->0 carrying to h; h wraps 23->0; 23:59:59 -> 00:00:00 in one tick.
REQ-018 inc_btn in SET_HOUR/SET_AL_HOUR increments hour mod 24; in SET_MIN/SET_AL_MIN increments minute mod 60; no carry into hour; ignored in RUN.
REQ-019 Leaving SET_MIN (mode_btn) clears s and divider to 0 in that cycle.
REQ-020 mode_btn and inc_btn in the same cycle: mode_btn acts, inc_btn ignored.
REQ-021 disp shows time in RUN/SET_HOUR/SET_MIN, alarm as {HH,MM,8'h00} in SET_AL_*; updated registered, one cycle after the state/field change.
REQ-022 12-hour mapping: h=0 -> 12, 1..12 -> h, 13..23 -> h-12; pm per REQ-011; fmt_12h=0 forces pm=0.
REQ-023 blink = 3'b100 in SET_HOUR/SET_AL_HOUR, 3'b010 in SET_MIN/SET_AL_MIN, 3'b000 otherwise.
REQ-024 ring sets in the cycle after a sec_tick that makes time equal alarm_h:alarm_m:00 with alarm_en=1, in any running state.
REQ-025 ring clears after RING_SECS further sec_ticks, on any mode_btn/inc_btn pulse (pulse consumed, no state/field effect), or immediately when alarm_en=0.
REQ-026 Alarm match while ring already high restarts nothing; ring duration counter is not reloaded.

Reset
REQ-027 clr=1 asynchronously forces: state RUN, divider 0, time 00:00:00, alarm 00:00, ring 0, sec_tick 0, blink 0, pm 0, disp 32'h0000_0000.
REQ-028 clr mid-edit or mid-ring returns to reset values; first sec_tick TICK_DIV cycles after clr deasserts.

Structure
REQ-029 Package clock_pkg holds the state enum, constants HOURS=24, MINUTES=60, SECONDS=60, and a function bin-to-2-digit-BCD (0..99).
REQ-030 One sub-module mod_counter (parameter MOD; ports clk, clr, inc, load0, value, carry) instanced for s, m, h, alarm_h, alarm_m.

Verification (TICK_DIV=4, RING_SECS=3)
REQ-031 Set time 23:59:59 via edit then run one tick -> disp 32'h0000_0000, no intermediate 24:xx value.
REQ-032 clr, then 3 mode_btn + 5 inc_btn -> alarm 05:00, disp 32'h0005_0000, blink 3'b100.
REQ-033 Alarm 00:01, alarm_en=1, run 60 ticks -> ring rises cycle after tick 60, falls after 3 more ticks.
REQ-034 Ring active, inc_btn pulse -> ring 0 next cycle, time and alarm unchanged, state RUN.
REQ-035 h=13, fmt_12h=1 -> disp hour digits 8'h01, pm 1; h=0 -> 8'h12, pm 0.
REQ-036 mode_btn and inc_btn same cycle in SET_HOUR -> state SET_MIN, hour unchanged; clr during SET_MIN -> all REQ-027 values.
